// File: rtl/matrix_tile_stream.sv
// Buffers one ROWS x COLS signed matrix and streams it out as COLS/TILE column tiles,
// one tile per valid/ready beat, with tile index, last flag, done pulse and flush.
module matrix_tile_stream #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 16,
    parameter int COLS   = 64,
    parameter int TILE   = 16,
    localparam int NT    = COLS / TILE,
    localparam int IDX_W = (NT > 1) ? $clog2(NT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*COLS*DATA_W-1:0] in_matrix,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ROWS*TILE*DATA_W-1:0] out_tile,
    output logic [IDX_W-1:0]            out_idx,
    output logic                        out_last,
    output logic                        done
);

    localparam int MAT_BITS  = ROWS * COLS * DATA_W;
    localparam int TILE_BITS = ROWS * TILE * DATA_W;
    localparam int ROW_BITS  = TILE * DATA_W;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                            state;
    state_t                            state_next;
    logic [MAT_BITS-1:0]               buffer;
    logic [IDX_W-1:0]                  idx;
    logic                              is_last;
    logic                              in_accept;
    logic                              tile_accept;
    logic [NT-1:0][TILE_BITS-1:0]      tiles;

    assign out_valid   = (state == SEND);
    assign is_last     = (idx == IDX_W'(NT - 1));
    assign out_last    = out_valid & is_last;
    assign tile_accept = out_valid & out_ready;
    // A new matrix may enter on the very beat that hands off the last tile, so the
    // stream continues without a bubble; flush and reset both block acceptance.
    assign in_ready    = rst & ~flush & ((state == IDLE) | (tile_accept & is_last));
    assign in_accept   = in_valid & in_ready;
    assign out_idx     = idx;

    // Each tile row is a contiguous slice of the matching matrix row, so tiles are wiring only.
    for (genvar t = 0; t < NT; t++) begin : g_tile
        for (genvar r = 0; r < ROWS; r++) begin : g_row
            assign tiles[t][(ROWS-1-r)*ROW_BITS +: ROW_BITS] =
                buffer[((ROWS-1-r)*COLS + COLS - (t+1)*TILE)*DATA_W +: ROW_BITS];
        end
    end

    if (NT == 1) begin : g_single
        assign out_tile = tiles[0];
    end else begin : g_mux
        assign out_tile = tiles[idx];
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_accept) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                if (flush) begin
                    state_next = IDLE;
                end else if (tile_accept && is_last && !in_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            buffer <= '0;
            idx    <= '0;
            done   <= 1'b0;
        end else begin
            state <= state_next;
            done  <= tile_accept & is_last & ~flush;
            if (flush) begin
                idx <= '0;
            end else if (in_accept) begin
                buffer <= in_matrix;
                idx    <= '0;
            end else if (tile_accept && !is_last) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_matrix_tile_stream.sv
// Directed bench for matrix_tile_stream: default 16x64/16 build plus NT=1 and small-geometry builds.
module tb_matrix_tile_stream;

    localparam int DW   = 16;
    localparam int R    = 16;
    localparam int C    = 64;
    localparam int T    = 16;
    localparam int MB   = R * C * DW;
    localparam int TBW  = R * T * DW;
    localparam int SDW  = 8;
    localparam int SR   = 4;
    localparam int SC   = 8;
    localparam int ST   = 2;
    localparam int SMB  = SR * SC * SDW;
    localparam int STBW = SR * ST * SDW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic flush = 1'b0;

    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [MB-1:0] in_matrix = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TBW-1:0] out_tile;
    logic [1:0]    out_idx;
    logic          out_last;
    logic          done;

    logic          b_in_valid = 1'b0;
    logic          b_in_ready;
    logic [MB-1:0] b_matrix = '0;
    logic          b_out_valid;
    logic          b_out_ready = 1'b0;
    logic [MB-1:0] b_out_tile;
    logic [0:0]    b_out_idx;
    logic          b_out_last;
    logic          b_done;

    logic           c_in_valid = 1'b0;
    logic           c_in_ready;
    logic [SMB-1:0] c_matrix = '0;
    logic           c_out_valid;
    logic           c_out_ready = 1'b0;
    logic [STBW-1:0] c_out_tile;
    logic [1:0]     c_out_idx;
    logic           c_out_last;
    logic           c_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    matrix_tile_stream #(.DATA_W(DW), .ROWS(R), .COLS(C), .TILE(T)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_matrix(in_matrix),
        .out_valid(out_valid), .out_ready(out_ready), .out_tile(out_tile),
        .out_idx(out_idx), .out_last(out_last), .done(done)
    );

    matrix_tile_stream #(.DATA_W(DW), .ROWS(R), .COLS(C), .TILE(C)) dut_single (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_matrix(b_matrix),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tile(b_out_tile),
        .out_idx(b_out_idx), .out_last(b_out_last), .done(b_done)
    );

    matrix_tile_stream #(.DATA_W(SDW), .ROWS(SR), .COLS(SC), .TILE(ST)) dut_small (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_matrix(c_matrix),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_tile(c_out_tile),
        .out_idx(c_out_idx), .out_last(c_out_last), .done(c_done)
    );

    // element (r,c) = base + r*64 + c
    function automatic logic [MB-1:0] mat_def(input int base);
        logic [MB-1:0] m;
        m = '0;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                m[((R-1-r)*C + (C-1-c))*DW +: DW] = 16'(base + r*64 + c);
        return m;
    endfunction

    // tile t element (r,j) = input element (r, t*16+j)
    function automatic logic [TBW-1:0] tile_def(input int base, input int t);
        logic [TBW-1:0] v;
        v = '0;
        for (int r = 0; r < R; r++)
            for (int j = 0; j < T; j++)
                v[((R-1-r)*T + (T-1-j))*DW +: DW] = 16'(base + r*64 + t*16 + j);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || done !== 1'b0 || out_last !== 1'b0 || out_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_ctrl got valid=%b done=%b last=%b idx=%0d want 0 0 0 0",
                     out_valid, done, out_last, out_idx);
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_in_ready got %b want 0", in_ready);
        end
        vectors++;
        if (out_tile !== '0) begin
            miscompares++;
            $display("FAIL reset_tile got top=%h want 0", out_tile[TBW-1 -: 32]);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        step();
        in_valid  = 1'b1;
        in_matrix = mat_def(0);
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_accept got in_ready=%b valid=%b want 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 2'(t) || out_last !== (t == 3) || done !== 1'b0) begin
                miscompares++;
                $display("FAIL single_beat%0d got valid=%b idx=%0d last=%b done=%b want 1 %0d %b 0",
                         t, out_valid, out_idx, out_last, done, t, (t == 3));
            end
            vectors++;
            if (out_tile !== tile_def(0, t)) begin
                miscompares++;
                $display("FAIL single_tile%0d got top=%h want top=%h", t,
                         out_tile[TBW-1 -: 32], tile_def(0, t) >> (TBW-32));
            end
            if (t == 1) begin
                vectors++;
                if (out_tile[TBW-1 -: DW] !== 16'd16) begin
                    miscompares++;
                    $display("FAIL tile1_elem00 got %0d want 16", out_tile[TBW-1 -: DW]);
                end
            end
            if (t == 3) begin
                vectors++;
                if (out_tile[DW-1:0] !== 16'd1023 || in_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL tile3_elem1515 got %0d in_ready=%b want 1023 1",
                             out_tile[DW-1:0], in_ready);
                end
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL single_done got done=%b valid=%b in_ready=%b want 1 0 1",
                     done, out_valid, in_ready);
        end
        step();
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin
            miscompares++;
            $display("FAIL single_done_width got %b want 0", done);
        end
    endtask

    task automatic test_stall();
        logic [7:0] pat;
        int exp_idx;
        logic took;
        pat = 8'b0110_1001;
        step();
        in_valid  = 1'b1;
        in_matrix = mat_def(8192);
        out_ready = 1'b0;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        in_matrix = mat_def(100);
        exp_idx = 0;
        for (int k = 0; k < 40 && exp_idx < 4; k++) begin
            out_ready = pat[k % 8];
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 2'(exp_idx) || out_tile !== tile_def(8192, exp_idx)) begin
                miscompares++;
                $display("FAIL stall_k%0d got valid=%b idx=%0d top=%h want 1 %0d top=%h", k,
                         out_valid, out_idx, out_tile[TBW-1 -: 32], exp_idx,
                         tile_def(8192, exp_idx) >> (TBW-32));
            end
            took = out_ready;
            step();
            if (took) exp_idx++;
        end
        vectors++;
        if (exp_idx != 4) begin
            miscompares++;
            $display("FAIL stall_budget got %0d tiles want 4", exp_idx);
        end
        out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done got done=%b valid=%b want 1 0", done, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int dones;
        dones = 0;
        step();
        in_valid  = 1'b1;
        in_matrix = mat_def(0);
        out_ready = 1'b1;
        @(negedge clk);
        step();
        in_matrix = mat_def(2048);
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            vectors++;
            if (out_idx !== 2'(t) || in_ready !== (t == 3) || out_tile !== tile_def(0, t)) begin
                miscompares++;
                $display("FAIL b2b_m1_beat%0d got idx=%0d in_ready=%b want %0d %b",
                         t, out_idx, in_ready, t, (t == 3));
            end
            step();
        end
        in_valid = 1'b0;
        @(negedge clk);
        if (done === 1'b1) dones++;
        vectors++;
        if (out_valid !== 1'b1 || out_idx !== 2'd0 || out_tile[TBW-1 -: DW] !== 16'd2048 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_m2_first got valid=%b idx=%0d elem00=%0d done=%b want 1 0 2048 1",
                     out_valid, out_idx, out_tile[TBW-1 -: DW], done);
        end
        step();
        for (int t = 1; t < 4; t++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            vectors++;
            if (out_idx !== 2'(t) || out_tile !== tile_def(2048, t)) begin
                miscompares++;
                $display("FAIL b2b_m2_beat%0d got idx=%0d want %0d", t, out_idx, t);
            end
            step();
        end
        @(negedge clk);
        if (done === 1'b1) dones++;
        vectors++;
        if (dones != 2 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_done_count got %0d valid=%b want 2 0", dones, out_valid);
        end
    endtask

    task automatic test_flush();
        int dones;
        dones = 0;
        step();
        in_valid  = 1'b1;
        in_matrix = mat_def(0);
        out_ready = 1'b1;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        step();
        @(negedge clk);
        step();
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_matrix = mat_def(4096);
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b0 || out_idx !== 2'd2) begin
            miscompares++;
            $display("FAIL flush_cycle got in_ready=%b idx=%0d want 0 2", in_ready, out_idx);
        end
        step();
        flush = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_after got valid=%b done=%b in_ready=%b want 0 0 1",
                     out_valid, done, in_ready);
        end
        step();
        in_valid = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            vectors++;
            if (out_valid !== 1'b1 || out_idx !== 2'(t) || out_tile !== tile_def(4096, t)) begin
                miscompares++;
                $display("FAIL flush_fresh_beat%0d got valid=%b idx=%0d top=%h want 1 %0d top=%h", t,
                         out_valid, out_idx, out_tile[TBW-1 -: 32], t,
                         tile_def(4096, t) >> (TBW-32));
            end
            step();
        end
        @(negedge clk);
        if (done === 1'b1) dones++;
        vectors++;
        if (dones != 1) begin
            miscompares++;
            $display("FAIL flush_done_count got %0d want 1", dones);
        end
    endtask

    task automatic test_async_reset();
        step();
        in_valid  = 1'b1;
        in_matrix = mat_def(0);
        out_ready = 1'b1;
        @(negedge clk);
        step();
        in_valid = 1'b0;
        @(negedge clk);
        step();
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_idx !== 2'd0 || done !== 1'b0 || in_ready !== 1'b0 || out_tile !== '0) begin
            miscompares++;
            $display("FAIL async_reset got valid=%b idx=%0d done=%b in_ready=%b want 0 0 0 0",
                     out_valid, out_idx, done, in_ready);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== 2'd0) begin
            miscompares++;
            $display("FAIL async_release got in_ready=%b valid=%b idx=%0d want 1 0 0",
                     in_ready, out_valid, out_idx);
        end
    endtask

    task automatic test_single_tile();
        logic [MB-1:0] m;
        for (int i = 0; i < MB/32; i++) m[i*32 +: 32] = $urandom();
        step();
        b_in_valid  = 1'b1;
        b_matrix    = m;
        b_out_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (b_in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL nt1_in_ready got %b want 1", b_in_ready);
        end
        step();
        b_in_valid = 1'b0;
        b_matrix   = ~m;
        for (int k = 0; k < 2; k++) begin
            b_out_ready = (k == 1);
            @(negedge clk);
            vectors++;
            if (b_out_valid !== 1'b1 || b_out_idx !== 1'b0 || b_out_last !== 1'b1 || b_out_tile !== m) begin
                miscompares++;
                $display("FAIL nt1_beat%0d got valid=%b idx=%0d last=%b top=%h want 1 0 1 top=%h", k,
                         b_out_valid, b_out_idx, b_out_last, b_out_tile[MB-1 -: 32], m[MB-1 -: 32]);
            end
            step();
        end
        @(negedge clk);
        vectors++;
        if (b_done !== 1'b1 || b_out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL nt1_done got done=%b valid=%b want 1 0", b_done, b_out_valid);
        end
        b_out_ready = 1'b0;
    endtask

    task automatic test_small_geometry();
        logic [SDW-1:0] e [SR][SC];
        logic [STBW-1:0] exp_tile;
        for (int n = 0; n < 2; n++) begin
            for (int r = 0; r < SR; r++)
                for (int c = 0; c < SC; c++)
                    e[r][c] = 8'($urandom_range(0, 255));
            step();
            for (int r = 0; r < SR; r++)
                for (int c = 0; c < SC; c++)
                    c_matrix[((SR-1-r)*SC + (SC-1-c))*SDW +: SDW] = e[r][c];
            c_in_valid  = 1'b1;
            c_out_ready = 1'b1;
            @(negedge clk);
            step();
            c_in_valid = 1'b0;
            for (int t = 0; t < SC/ST; t++) begin
                exp_tile = '0;
                for (int r = 0; r < SR; r++)
                    for (int j = 0; j < ST; j++)
                        exp_tile[((SR-1-r)*ST + (ST-1-j))*SDW +: SDW] = e[r][t*ST + j];
                @(negedge clk);
                vectors++;
                if (c_out_valid !== 1'b1 || c_out_idx !== 2'(t) || c_out_last !== (t == 3) || c_out_tile !== exp_tile) begin
                    miscompares++;
                    $display("FAIL small_m%0d_t%0d got valid=%b idx=%0d last=%b tile=%h want 1 %0d %b %h",
                             n, t, c_out_valid, c_out_idx, c_out_last, c_out_tile, t, (t == 3), exp_tile);
                end
                step();
            end
            @(negedge clk);
            vectors++;
            if (c_done !== 1'b1) begin
                miscompares++;
                $display("FAIL small_m%0d_done got %b want 1", n, c_done);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stall();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_single_tile();
        test_small_geometry();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
